// File: rtl/nibble_adder_seq.sv
// WIDTH-bit add/subtract built from one shared 4-bit ripple-carry slice,
// one nibble per clock from the LSB up, with valid/ready request and response.

module nibble_add4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[4];
endmodule

module nibble_adder_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             ovf,
   output logic             busy
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic             cout_q, cout_d, ovf_q, ovf_d;

   logic [3:0] a_nib, b_nib, nib;
   logic       c4, last;

   assign a_nib = a_q[4*idx_q +: 4];
   assign b_nib = b_q[4*idx_q +: 4];
   assign last  = (idx_q == IW'(NIB - 1));

   nibble_add4 u_slice (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry_q),
      .s  (nib),
      .co (c4)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start_valid) begin
               // Subtract is folded into the add path as A + ~B + 1.
               a_d     = A;
               b_d     = op_sub ? ~B : B;
               carry_d = op_sub ? 1'b1 : Cin;
               idx_d   = '0;
               s_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[4*idx_q +: 4] = nib;
            carry_d           = c4;
            idx_d             = idx_q + 1'b1;
            if (last) begin
               cout_d  = c4;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib[3] != a_q[WIDTH-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign start_ready = (state_q == IDLE);
   assign res_valid   = (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign S           = s_q;
   assign Cout        = cout_q;
   assign ovf         = ovf_q;
endmodule
